// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types for the USB receive deserializer: bus line states, FSM states
// and the protocol constants used by the decoder and the framing FSM.
package usb_rx_deserializer_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } rx_state_t;

  // SYNC needs at least this many decoded zeros before its closing one.
  localparam int unsigned SYNC_MIN_ZEROS = 5;
  // A run of this many ones forces a stuff bit into the next position.
  localparam int unsigned STUFF_RUN      = 6;

  function automatic logic is_jk(input line_state_t ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_rx_deserializer_unstuff.sv
// NRZI decoder and bit unstuffer. Unstuffing is only active while data_mode
// is high; stuff_err is only generated when USB_RX_ERR_EN is defined.
module usb_rx_unstuff
  import usb_rx_deserializer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_strobe,
  input  line_state_t line_state,
  input  logic        data_mode,
  output logic        dec_bit,
  output logic        bit_valid,
  output logic        stuff_err
);

  line_state_t prev_ls;
  logic [2:0]  ones_cnt;
  logic        strobe_jk;
  logic        stuff_pos;

  assign strobe_jk = bit_strobe && is_jk(line_state);
  assign dec_bit   = (line_state == prev_ls);
  assign stuff_pos = data_mode && (ones_cnt == 3'(STUFF_RUN));
  assign bit_valid = strobe_jk && !stuff_pos;

`ifdef USB_RX_ERR_EN
  assign stuff_err = strobe_jk && stuff_pos && dec_bit;
`else
  assign stuff_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ls  <= LS_J;
      ones_cnt <= '0;
    end else begin
      if (strobe_jk)
        prev_ls <= line_state;
      // The stuff position always restarts the run, whether the bit was a
      // legal zero or a violating one.
      if (!data_mode)
        ones_cnt <= '0;
      else if (strobe_jk)
        ones_cnt <= (stuff_pos || !dec_bit) ? 3'd0 : ones_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: SYNC detection, byte assembly and EOP framing.
// Define USB_RX_ERR_EN to build stuff/alignment/SE1 error detection.
module usb_rx_deserializer
  import usb_rx_deserializer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  line_state_t line_state,
  input  logic        bit_strobe,
  output logic [7:0]  rx_data,
  output logic        rx_active,
  output logic        rx_valid,
  output logic        rx_error
);

  rx_state_t   state, state_nxt;
  logic [2:0]  zero_cnt, zero_nxt;
  logic [2:0]  bit_cnt, bcnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data_nxt;
  logic        active_nxt, valid_nxt, err_nxt;
  line_state_t ls;
  logic        dec_bit, bit_valid, stuff_err;

`ifdef USB_RX_ERR_EN
  logic se0_seen, se0_nxt;
  assign ls = line_state;
`else
  logic unused_stuff_err;
  assign unused_stuff_err = stuff_err;
  // Without error detection an SE1 is simply an early end of packet.
  assign ls = (line_state == LS_SE1) ? LS_SE0 : line_state;
`endif

  usb_rx_unstuff u_unstuff (
    .clk        (clk),
    .reset      (reset),
    .bit_strobe (bit_strobe),
    .line_state (line_state),
    .data_mode  (state == ST_DATA),
    .dec_bit    (dec_bit),
    .bit_valid  (bit_valid),
    .stuff_err  (stuff_err)
  );

  always_comb begin
    state_nxt  = state;
    zero_nxt   = zero_cnt;
    bcnt_nxt   = bit_cnt;
    shreg_nxt  = shreg;
    data_nxt   = rx_data;
    active_nxt = rx_active;
    valid_nxt  = 1'b0;
`ifdef USB_RX_ERR_EN
    err_nxt    = rx_error;
    se0_nxt    = se0_seen;
`else
    err_nxt    = 1'b0;
`endif
    if (bit_strobe) begin
      case (state)
        ST_IDLE: begin
          if (ls == LS_K) begin
            state_nxt = ST_SYNC;
            zero_nxt  = '0;
          end
        end
        ST_SYNC: begin
          if (ls == LS_SE0)
            state_nxt = ST_IDLE;
`ifdef USB_RX_ERR_EN
          else if (ls == LS_SE1) begin
            state_nxt = ST_ERROR;
            err_nxt   = rx_active;
          end
`endif
          else if (!dec_bit)
            zero_nxt = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
          else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
            state_nxt  = ST_DATA;
            active_nxt = 1'b1;
            bcnt_nxt   = '0;
          end else
            state_nxt = ST_IDLE;
        end
        ST_DATA: begin
          if (ls == LS_SE0) begin
            // A partial byte at EOP is never presented.
            state_nxt = ST_EOP;
            bcnt_nxt  = '0;
`ifdef USB_RX_ERR_EN
            if (bit_cnt != 3'd0)
              err_nxt = 1'b1;
`endif
          end
`ifdef USB_RX_ERR_EN
          else if ((ls == LS_SE1) || stuff_err) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end
`endif
          else if (bit_valid) begin
            shreg_nxt = {dec_bit, shreg[7:1]};
            bcnt_nxt  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_nxt  = {dec_bit, shreg[7:1]};
              valid_nxt = 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (ls == LS_J) begin
            state_nxt  = ST_IDLE;
            active_nxt = 1'b0;
            err_nxt    = 1'b0;
          end
`ifdef USB_RX_ERR_EN
          else if (ls == LS_SE1) begin
            state_nxt = ST_ERROR;
            err_nxt   = rx_active;
          end
`endif
        end
`ifdef USB_RX_ERR_EN
        ST_ERROR: begin
          if (ls == LS_SE0)
            se0_nxt = 1'b1;
          else if ((ls == LS_J) && se0_seen) begin
            state_nxt  = ST_IDLE;
            active_nxt = 1'b0;
            err_nxt    = 1'b0;
            se0_nxt    = 1'b0;
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      zero_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
`ifdef USB_RX_ERR_EN
      se0_seen  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      zero_cnt  <= zero_nxt;
      bit_cnt   <= bcnt_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_active <= active_nxt;
      rx_valid  <= valid_nxt;
      rx_error  <= err_nxt;
`ifdef USB_RX_ERR_EN
      se0_seen  <= se0_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench: NRZI/stuffing encoder drives packets with random strobe
// gaps; expected bytes/errors come from a bit-list decoder model.
module tb_usb_rx_deserializer;
  import usb_rx_deserializer_pkg::*;

`ifdef USB_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  line_state_t line_state;
  logic        bit_strobe;
  logic [7:0]  rx_data;
  logic        rx_active, rx_valid, rx_error;

  int checks   = 0;
  int failures = 0;
  int max_gap  = 2;

  line_state_t enc_lvl = LS_J;
  bit          tx_bits[$];
  int          tx_run;
  logic [7:0]  exp_q[$];
  bit          exp_err;

  // Monitor-owned records; tests snapshot them instead of clearing them.
  logic [7:0]  got[$];
  int          err_cnt = 0, both_cnt = 0, hold_cnt = 0, drop_cnt = 0;
  logic [7:0]  last_data = '0;
  logic        last_err = 1'b0;

  usb_rx_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .line_state (line_state),
    .bit_strobe (bit_strobe),
    .rx_data    (rx_data),
    .rx_active  (rx_active),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) got.push_back(rx_data);
    if (rx_error) err_cnt++;
    if (rx_error && rx_valid) both_cnt++;
    if (reset && (rx_data !== last_data) && !rx_valid) hold_cnt++;
    if (last_err && !rx_error && rx_active) drop_cnt++;
    last_data = rx_data;
    last_err  = rx_error;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_ls(input line_state_t l);
    int gap;
    gap = $urandom_range(max_gap, 0);
    for (int g = 0; g < gap; g++) begin
      line_state = line_state_t'(2'($urandom_range(3, 0)));
      @(posedge clk); #1;
    end
    line_state = l;
    bit_strobe = 1'b1;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    if (!b) enc_lvl = line_state_t'(enc_lvl ^ 2'b11);
    send_ls(enc_lvl);
  endtask

  task automatic send_sync();
    send_ls(LS_J); send_ls(LS_J);
    send_ls(LS_K); send_ls(LS_J); send_ls(LS_K); send_ls(LS_J);
    send_ls(LS_K); send_ls(LS_J); send_ls(LS_K); send_ls(LS_K);
    enc_lvl = LS_K;
  endtask

  task automatic add_bits(input logic [7:0] v, input int n, input bit stuff_en);
    for (int i = 0; i < n; i++) begin
      tx_bits.push_back(v[i]);
      tx_run = v[i] ? tx_run + 1 : 0;
      if (stuff_en && tx_run >= 6) begin
        tx_bits.push_back(1'b0);
        tx_run = 0;
      end
    end
  endtask

  task automatic new_packet();
    tx_bits.delete();
    tx_run = 0;
  endtask

  // Reference: walk the transmitted bit list, drop the bit after six ones,
  // pack survivors LSB-first into bytes.
  task automatic model(input bit se1_end);
    int run, n;
    logic [7:0] acc;
    run = 0; n = 0; acc = '0;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (run == 6) begin
        if (tx_bits[i] && ERR_EN) begin
          exp_err = 1'b1;
          break;
        end
        run = 0;
      end else begin
        acc[n] = tx_bits[i];
        n++;
        run = tx_bits[i] ? run + 1 : 0;
        if (n == 8) begin
          exp_q.push_back(acc);
          n = 0;
        end
      end
    end
    if (ERR_EN && (n != 0 || se1_end)) exp_err = 1'b1;
  endtask

  task automatic run_packet(input string nm, input bit se1_end);
    int gb, eb, bb, hb, db;
    logic [7:0] g;
    gb = got.size(); eb = err_cnt; bb = both_cnt; hb = hold_cnt; db = drop_cnt;
    model(se1_end);
    send_sync();
    foreach (tx_bits[i]) send_bit(tx_bits[i]);
    if (se1_end) send_ls(LS_SE1);
    send_ls(LS_SE0);
    send_ls(LS_SE0);
    checks++;
    if (rx_active !== 1'b1) begin
      failures++;
      $display("FAIL %s active_before_j: got %b want 1", nm, rx_active);
    end
    send_ls(LS_J);
    enc_lvl = LS_J;
    checks++;
    if (rx_active !== 1'b0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after_j: active=%b error=%b want 0 0", nm, rx_active, rx_error);
    end
    @(negedge clk); #1;
    checks++;
    if (got.size() - gb != exp_q.size()) begin
      failures++;
      $display("FAIL %s byte_count: got %0d want %0d", nm, got.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (gb + i < got.size()) ? got[gb + i] : 8'hxx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("FAIL %s byte%0d: got %h want %h", nm, i, g, exp_q[i]);
      end
    end
    checks++;
    if ((err_cnt > eb) !== exp_err) begin
      failures++;
      $display("FAIL %s error_seen: got %b want %b", nm, err_cnt > eb, exp_err);
    end
    checks++;
    if (both_cnt != bb || hold_cnt != hb || drop_cnt != db) begin
      failures++;
      $display("FAIL %s invariants: err+valid=%0d data_changed=%0d err_dropped=%0d want 0 0 0",
               nm, both_cnt - bb, hold_cnt - hb, drop_cnt - db);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bit_strobe = 1'b0; line_state = LS_J;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_active !== 1'b0 || rx_valid !== 1'b0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h active=%b valid=%b error=%b want 00 0 0 0",
               rx_data, rx_active, rx_valid, rx_error);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sync_byte();
    int gb;
    max_gap = 0;
    new_packet();
    add_bits(8'hE1, 8, 1'b1);
    gb = got.size();
    send_ls(LS_J);
    send_ls(LS_K); send_ls(LS_J); send_ls(LS_K); send_ls(LS_J);
    send_ls(LS_K); send_ls(LS_J); send_ls(LS_K);
    checks++;
    if (rx_active !== 1'b0) begin
      failures++;
      $display("FAIL sync_active_early: got %b want 0", rx_active);
    end
    send_ls(LS_K);
    enc_lvl = LS_K;
    checks++;
    if (rx_active !== 1'b1) begin
      failures++;
      $display("FAIL sync_active_rise: got %b want 1", rx_active);
    end
    foreach (tx_bits[i]) send_bit(tx_bits[i]);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hE1) begin
      failures++;
      $display("FAIL sync_byte_latency: valid=%b data=%h want 1 e1", rx_valid, rx_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hE1) begin
      failures++;
      $display("FAIL sync_valid_pulse: valid=%b data=%h want 0 e1", rx_valid, rx_data);
    end
    send_ls(LS_SE0); send_ls(LS_SE0);
    checks++;
    if (rx_active !== 1'b1) begin
      failures++;
      $display("FAIL sync_active_eop: got %b want 1", rx_active);
    end
    send_ls(LS_J);
    enc_lvl = LS_J;
    checks++;
    if (rx_active !== 1'b0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL sync_active_fall: active=%b error=%b want 0 0", rx_active, rx_error);
    end
    @(negedge clk); #1;
    checks++;
    if (got.size() - gb != 1) begin
      failures++;
      $display("FAIL sync_valid_count: got %0d want 1", got.size() - gb);
    end
    max_gap = 2;
  endtask

  task automatic test_stuffing();
    new_packet();
    add_bits(8'hFF, 8, 1'b1);
    add_bits(8'h01, 8, 1'b1);
    run_packet("stuffing", 1'b0);
  endtask

  task automatic test_stuff_violation();
    new_packet();
    add_bits(8'hFF, 8, 1'b0);
    add_bits(8'h01, 8, 1'b1);
    run_packet("stuff_violation", 1'b0);
  endtask

  task automatic test_alignment();
    new_packet();
    add_bits(8'h3C, 8, 1'b1);
    add_bits(8'h0A, 4, 1'b1);
    run_packet("alignment", 1'b0);
  endtask

  task automatic test_se1();
    new_packet();
    add_bits(8'hA5, 8, 1'b1);
    run_packet("se1", 1'b1);
  endtask

  task automatic test_reset_mid();
    int gb;
    new_packet();
    add_bits(8'hC3, 8, 1'b1);
    add_bits(8'h5A, 4, 1'b1);
    gb = got.size();
    send_sync();
    foreach (tx_bits[i]) send_bit(tx_bits[i]);
    checks++;
    if (rx_data !== 8'hC3 || rx_active !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: data=%h active=%b want c3 1", rx_data, rx_active);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_active !== 1'b0 || rx_valid !== 1'b0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: data=%h active=%b valid=%b error=%b want 00 0 0 0",
               rx_data, rx_active, rx_valid, rx_error);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    enc_lvl = LS_J;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got.size() - gb != 1) begin
      failures++;
      $display("FAIL reset_mid_no_valid: got %0d bytes want 1", got.size() - gb);
    end
    new_packet();
    add_bits(8'h2D, 8, 1'b1);
    run_packet("after_reset", 1'b0);
  endtask

  task automatic test_random();
    int nb;
    bit viol;
    logic [7:0] v;
    for (int p = 0; p < 16; p++) begin
      new_packet();
      nb   = $urandom_range(4, 1);
      viol = ($urandom_range(5, 0) == 0);
      for (int b = 0; b < nb; b++) begin
        v = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
        if (viol && b == 0) v = 8'hFF;
        add_bits(v, 8, !(viol && b == 0));
      end
      if ($urandom_range(2, 0) == 0) add_bits(8'($urandom), $urandom_range(7, 1), 1'b1);
      run_packet($sformatf("random%0d", p), $urandom_range(7, 0) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_sync_byte();
    test_stuffing();
    test_stuff_violation();
    test_alignment();
    test_se1();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_deserializer.md
USB_RX_DESERIALIZER -- requirements
Module: usb_rx_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock, 24 MHz.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 line_state  input  2  synchronised bus state, type line_state_t: SE0=00, J=01, K=10, SE1=11.
REQ-005 bit_strobe  input  1  one-clk pulse at the centre of each received bit, from the external DPLL.
REQ-006 rx_data  output  8  last assembled byte, LSB received first.
REQ-007 rx_active  output  1  high from SYNC accepted until end of EOP.
REQ-008 rx_valid  output  1  one-clk pulse when rx_data holds a new byte.
REQ-009 rx_error  output  1  stuff, alignment or SE1 error; held until rx_active falls.

Function
REQ-010 The block SHALL act only on cycles with bit_strobe=1; all other cycles hold state.
REQ-011 NRZI decode SHALL work as follows: decoded bit = 1 if line_state equals the previous strobed J/K state, 0 if it differs; the previous state resets to J.
REQ-012 States SHALL be IDLE, SYNC, DATA, EOP and ERROR.
REQ-013 IDLE SHALL go to SYNC on a strobed K, with the zero counter cleared.
REQ-014 In SYNC, a decoded 0 SHALL increment the zero counter (saturating at 7).
REQ-015 In SYNC, a decoded 1 with zero counter >= 5 SHALL go to DATA and set rx_active the next clk.
REQ-016 In SYNC, a decoded 1 with counter < 5, or SE0, SHALL return to IDLE with rx_active staying 0.
REQ-017 In DATA, the ones counter SHALL increment on 1 and clear on 0.
REQ-018 After six consecutive 1s, the next bit SHALL be a stuff bit: a 0 is discarded and not counted, and clears the ones counter.
REQ-019 A 1 in the stuff position SHALL be a stuff error: set rx_error and go to ERROR.
REQ-020 Non-stuff bits SHALL shift into the byte register LSB-first; the 3-bit bit counter wraps 7->0.
REQ-021 On the 8th bit, rx_data SHALL be loaded and rx_valid pulsed in the clk following that strobe (latency 1 clk).
REQ-022 A strobed SE0 in DATA SHALL go to EOP; if the bit counter is not 0, rx_error SHALL be set (alignment error) and the partial byte dropped.
REQ-023 EOP SHALL wait for a strobed J, then clear rx_active and rx_error in the following clk and go to IDLE; further SE0 strobes are ignored.
REQ-024 A strobed SE1 in SYNC/DATA/EOP SHALL set rx_error (if rx_active) and go to ERROR.
REQ-025 ERROR SHALL emit no rx_valid and wait for SE0 followed by J, then clear rx_active/rx_error and go to IDLE.
REQ-026 rx_error=1 and rx_valid=1 SHALL never be asserted in the same clk.
REQ-027 rx_data SHALL hold its value between rx_valid pulses.

Reset
REQ-028 While reset=0, all of the following SHALL apply immediately: state=IDLE, rx_data=0, rx_active=0, rx_valid=0, rx_error=0, all counters 0, previous line state=J.
REQ-029 Reset mid-packet SHALL abort without a further rx_valid; the first packet after release SHALL decode normally.

Configuration
REQ-030 Macro USB_RX_ERR_EN defined: stuff, alignment and SE1 detection SHALL be built as in REQ-019/022/024.
REQ-031 Macro undefined: rx_error SHALL be tied 0; the bit after six 1s SHALL always be discarded; SE1 is treated as SE0; the partial byte at EOP is dropped silently; ERROR is not built.

Structure
REQ-032 line_state_t and the state enum SHALL live in the shared package types.
REQ-033 NRZI decode plus bit unstuffing SHALL be one sub-module, usb_rx_unstuff, outputting bit, bit_valid and stuff_err.

Verification
REQ-034 SYNC KJKJKJKK, then byte 0xE1, then SE0,SE0,J -> exactly one rx_valid with rx_data=0xE1; rx_active 1 from the clk after the last SYNC K until the clk after J.
REQ-035 Bytes 0xFF, 0x01 with a stuffed 0 after the sixth 1 -> rx_valid 0xFF then 0x01, with rx_error=0 throughout.
REQ-036 Seven consecutive 1s without a stuff bit -> rx_error=1 until rx_active falls, and no rx_valid for that byte (USB_RX_ERR_EN defined).
REQ-037 SYNC, then 12 data bits, then SE0,SE0,J -> one rx_valid, then rx_error=1, and rx_active=0 after J.
REQ-038 reset=0 asserted at bit 4 of a byte -> all outputs 0 in the same clk; the next packet with 0x2D decodes to rx_data=0x2D.
REQ-039 Macro undefined, stimulus as REQ-036 -> rx_error stays 0 and the packet ends normally on EOP.
